// File: rtl/xcap_pkg.sv
// Shared constants and elaboration helpers for the X-engine output capture block.
// Field slots are numbered from the LSB, so XX_R is the most significant field of a word.
package xcap_pkg;

  localparam int XX_R = 7;
  localparam int XX_I = 6;
  localparam int XY_R = 5;
  localparam int XY_I = 4;
  localparam int YX_R = 3;
  localparam int YX_I = 2;
  localparam int YY_R = 1;
  localparam int YY_I = 0;
  localparam int N_FIELDS = XX_R + 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_ACCUM     = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  localparam int ERR_SAT     = 2;
  localparam int ERR_RESYNC  = 1;
  localparam int ERR_OVERRUN = 0;

  // Baselines produced per correlator window, including autocorrelations.
  function automatic int out_words(input int n_ants);
    return n_ants * (n_ants / 2 + 1);
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/xcap_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
// Read returns the pre-write contents when both ports hit the same address.
module xcap_acc_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; window 0 overwrites every entry instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/xeng_out_capture.sv
// Captures the X-engine output stream and integrates acc_len windows per baseline word
// into a saturating vector accumulator, readable once the capture has completed.
module xeng_out_capture
  import xcap_pkg::*;
#(
  parameter int N_ANTS      = 32,
  parameter int IN_FIELD_W  = 19,
  parameter int OUT_FIELD_W = 32,
  parameter int MCNT_WIDTH  = 48,
  parameter int ACC_LEN_W   = 16,
  localparam int OUT_WORDS  = out_words(N_ANTS),
  localparam int ADDR_W     = clog2(OUT_WORDS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arm,
  input  logic [ACC_LEN_W-1:0]            acc_len,
  input  logic                            din_sync,
  input  logic                            din_vld,
  input  logic [N_FIELDS*IN_FIELD_W-1:0]  din,
  input  logic [MCNT_WIDTH-1:0]           din_mcnt,
  input  logic                            rd_en,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic [N_FIELDS*OUT_FIELD_W-1:0] rd_data,
  output logic                            rd_vld,
  output logic                            busy,
  output logic                            done,
  output logic [MCNT_WIDTH-1:0]           mcnt_first,
  output logic [2:0]                      err
);

  localparam int DIN_W = N_FIELDS * IN_FIELD_W;
  localparam int ACC_W = N_FIELDS * OUT_FIELD_W;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(OUT_WORDS - 1);

  logic [1:0]           state;
  logic                 draining;
  logic [1:0]           drain_cnt;
  logic [ADDR_W-1:0]    word_cnt;
  logic [ACC_LEN_W-1:0] win_cnt;
  logic [ACC_LEN_W-1:0] acc_len_r;

  logic                 start_sync;
  logic                 resync;
  logic                 accept;
  logic                 overrun;
  logic                 last_word;
  logic                 final_word;
  logic [ADDR_W-1:0]    word_idx;
  logic [ACC_LEN_W-1:0] win_idx;

  logic                 s1_vld;
  logic                 s1_ovw;
  logic [ADDR_W-1:0]    s1_addr;
  logic [DIN_W-1:0]     s1_din;
  logic                 s2_vld;
  logic [ADDR_W-1:0]    s2_addr;
  logic [ACC_W-1:0]     s2_data;
  logic [ACC_W-1:0]     sum_data;
  logic [N_FIELDS-1:0]  field_sat;
  logic                 sat_hit;

  logic                 rd_ok;
  logic                 rd_in_range;
  logic                 rd_p1;
  logic                 rd_oor_p1;
  logic [ADDR_W-1:0]    ram_raddr;
  logic [ACC_W-1:0]     ram_q;

  // A sync (first or restart) makes the coincident word, if any, word 0 of window 0.
  always_comb begin
    start_sync = (state == ST_WAIT_SYNC) && din_sync;
    resync     = (state == ST_ACCUM) && !draining && din_sync && (word_cnt != '0);
    accept     = din_vld && !arm && (start_sync || ((state == ST_ACCUM) && !draining));
    overrun    = din_vld && (((state == ST_ACCUM) && draining) || (state == ST_DONE));
    word_idx   = (start_sync || resync) ? '0 : word_cnt;
    win_idx    = (start_sync || resync) ? '0 : win_cnt;
    last_word  = (word_idx == LAST_WORD);
    final_word = accept && last_word && (win_idx == acc_len_r - ACC_LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      draining   <= 1'b0;
      drain_cnt  <= '0;
      word_cnt   <= '0;
      win_cnt    <= '0;
      acc_len_r  <= ACC_LEN_W'(1);
      done       <= 1'b0;
      err        <= '0;
      mcnt_first <= '0;
    end else if (arm) begin
      state     <= ST_WAIT_SYNC;
      draining  <= 1'b0;
      drain_cnt <= '0;
      word_cnt  <= '0;
      win_cnt   <= '0;
      acc_len_r <= (acc_len == '0) ? ACC_LEN_W'(1) : acc_len;
      done      <= 1'b0;
      err       <= '0;
    end else begin
      if (sat_hit) err[ERR_SAT]     <= 1'b1;
      if (resync)  err[ERR_RESYNC]  <= 1'b1;
      if (overrun) err[ERR_OVERRUN] <= 1'b1;
      if (start_sync) state <= ST_ACCUM;
      if (start_sync || resync) begin
        word_cnt <= '0;
        win_cnt  <= '0;
      end
      if (accept) begin
        if (last_word) begin
          word_cnt <= '0;
          win_cnt  <= win_idx + ACC_LEN_W'(1);
        end else begin
          word_cnt <= word_idx + ADDR_W'(1);
          win_cnt  <= win_idx;
        end
        if ((word_idx == '0) && (win_idx == '0)) mcnt_first <= din_mcnt;
      end
      // Hold off DONE until the last read-modify-write has landed in the RAM.
      if (final_word) begin
        draining  <= 1'b1;
        drain_cnt <= '0;
      end else if (draining) begin
        if (drain_cnt == 2'd2) begin
          draining <= 1'b0;
          state    <= ST_DONE;
          done     <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt + 2'd1;
        end
      end
    end
  end

  assign busy = (state == ST_WAIT_SYNC) || (state == ST_ACCUM);

  // Read-modify-write pipeline: S0 reads the RAM, S1 adds, S2 writes back.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
    end
  end

  always_ff @(posedge clk) begin
    s1_ovw  <= (win_idx == '0);
    s1_addr <= word_idx;
    s1_din  <= din;
    s2_addr <= s1_addr;
    s2_data <= sum_data;
  end

  for (genvar f = 0; f < N_FIELDS; f++) begin : g_field
    logic [OUT_FIELD_W-1:0] ext;
    logic [OUT_FIELD_W-1:0] prev;
    logic [OUT_FIELD_W:0]   wide;
    logic                   ovf;

    assign ext  = {{(OUT_FIELD_W - IN_FIELD_W){s1_din[(f + 1) * IN_FIELD_W - 1]}},
                   s1_din[f * IN_FIELD_W +: IN_FIELD_W]};
    assign prev = ram_q[f * OUT_FIELD_W +: OUT_FIELD_W];
    assign wide = {ext[OUT_FIELD_W-1], ext} + {prev[OUT_FIELD_W-1], prev};
    assign ovf  = !s1_ovw && (wide[OUT_FIELD_W] != wide[OUT_FIELD_W-1]);

    assign field_sat[f] = ovf;
    assign sum_data[f * OUT_FIELD_W +: OUT_FIELD_W] =
        s1_ovw ? ext :
        !ovf   ? wide[OUT_FIELD_W-1:0] :
        wide[OUT_FIELD_W] ? {1'b1, {(OUT_FIELD_W - 1){1'b0}}}
                          : {1'b0, {(OUT_FIELD_W - 1){1'b1}}};
  end

  assign sat_hit = s1_vld && (|field_sat);

  // The single read port serves the accumulator while capturing and the CPU otherwise.
  always_comb begin
    rd_ok       = rd_en && ((state == ST_IDLE) || (state == ST_DONE));
    rd_in_range = (32'(rd_addr) < 32'(OUT_WORDS));
    ram_raddr   = rd_ok ? (rd_in_range ? rd_addr : '0) : word_idx;
  end

  xcap_acc_ram #(
    .DEPTH  (OUT_WORDS),
    .WIDTH  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (s2_vld),
    .waddr (s2_addr),
    .wdata (s2_data),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1     <= 1'b0;
      rd_oor_p1 <= 1'b0;
      rd_vld    <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_p1     <= rd_ok;
      rd_oor_p1 <= !rd_in_range;
      rd_vld    <= rd_p1;
      if (rd_p1) rd_data <= rd_oor_p1 ? '0 : ram_q;
    end
  end

endmodule

// File: tb/tb_xeng_out_capture.sv
// Scoreboard bench for xeng_out_capture: two instances (32-bit and 20-bit accumulators)
// share one input stream; readout expectations are queued and checked by monitors.
module tb_xeng_out_capture;

  logic         clk = 1'b0;
  logic         rst;
  logic         arm_a, arm_b;
  logic [15:0]  acc_len;
  logic         din_sync, din_vld;
  logic [151:0] din;
  logic [47:0]  din_mcnt;
  logic         rd_en_a, rd_en_b;
  logic [3:0]   rd_addr;

  logic [255:0] rd_data_a;
  logic         rd_vld_a, busy_a, done_a;
  logic [47:0]  mcnt_first_a;
  logic [2:0]   err_a;
  logic [159:0] rd_data_b;
  logic         rd_vld_b, busy_b, done_b;
  logic [47:0]  mcnt_first_b;
  logic [2:0]   err_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] exp_a [$];
  logic [159:0] exp_b [$];
  logic [255:0] exp_word_a;
  logic [159:0] exp_word_b;

  always #5 clk = ~clk;

  xeng_out_capture #(
    .N_ANTS(4), .IN_FIELD_W(19), .OUT_FIELD_W(32), .MCNT_WIDTH(48), .ACC_LEN_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .arm(arm_a), .acc_len(acc_len), .din_sync(din_sync),
    .din_vld(din_vld), .din(din), .din_mcnt(din_mcnt), .rd_en(rd_en_a),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_vld(rd_vld_a), .busy(busy_a),
    .done(done_a), .mcnt_first(mcnt_first_a), .err(err_a)
  );

  xeng_out_capture #(
    .N_ANTS(4), .IN_FIELD_W(19), .OUT_FIELD_W(20), .MCNT_WIDTH(48), .ACC_LEN_W(16)
  ) u_dut_b (
    .clk(clk), .rst(rst), .arm(arm_b), .acc_len(acc_len), .din_sync(din_sync),
    .din_vld(din_vld), .din(din), .din_mcnt(din_mcnt), .rd_en(rd_en_b),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_vld(rd_vld_b), .busy(busy_b),
    .done(done_b), .mcnt_first(mcnt_first_b), .err(err_b)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rd_vld_a) begin
      n_cmp++;
      if (exp_a.size() == 0) begin
        n_bad++;
        $display("FAIL rd_a_unexpected: got rd_vld=1 data=%0h required no read", rd_data_a);
      end else begin
        exp_word_a = exp_a.pop_front();
        if (rd_data_a !== exp_word_a) begin
          n_bad++;
          $display("FAIL rd_data_a: got %0h required %0h", rd_data_a, exp_word_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rd_vld_b) begin
      n_cmp++;
      if (exp_b.size() == 0) begin
        n_bad++;
        $display("FAIL rd_b_unexpected: got rd_vld=1 data=%0h required no read", rd_data_b);
      end else begin
        exp_word_b = exp_b.pop_front();
        if (rd_data_b !== exp_word_b) begin
          n_bad++;
          $display("FAIL rd_data_b: got %0h required %0h", rd_data_b, exp_word_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Field f (0 = xx_r, 7 = yy_i) carries base + step*f.
  function automatic logic [151:0] mk_din(input int base, input int step);
    logic [151:0] d;
    for (int f = 0; f < 8; f++) d[(7 - f) * 19 +: 19] = 19'(base + step * f);
    return d;
  endfunction

  function automatic logic [255:0] mk_exp(input int base, input int step);
    logic [255:0] e;
    for (int f = 0; f < 8; f++) e[(7 - f) * 32 +: 32] = 32'(base + step * f);
    return e;
  endfunction

  task automatic arm_dut_a(input int len);
    acc_len = 16'(len);
    arm_a = 1'b1;
    tick();
    arm_a = 1'b0;
  endtask

  task automatic send(input logic sync, input logic [151:0] d, input logic [47:0] m);
    din_vld  = 1'b1;
    din_sync = sync;
    din      = d;
    din_mcnt = m;
    tick();
    din_vld  = 1'b0;
    din_sync = 1'b0;
  endtask

  task automatic send_window(input logic sync, input int base, input int step, input int m0);
    for (int k = 0; k < 12; k++) send(sync && (k == 0), mk_din(base, step), 48'(m0 + k));
  endtask

  task automatic wait_done(input logic use_b, output int cycles);
    cycles = 0;
    while (!(use_b ? done_b : done_a) && cycles < 40) begin
      tick();
      cycles++;
    end
    check(use_b ? "done_b_timeout" : "done_a_timeout", 256'(use_b ? done_b : done_a), 256'(1));
  endtask

  task automatic read_a(input int addr, input logic [255:0] exp);
    exp_a.push_back(exp);
    rd_addr = 4'(addr);
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
  endtask

  task automatic read_b(input int addr, input logic [159:0] exp);
    exp_b.push_back(exp);
    rd_addr = 4'(addr);
    rd_en_b = 1'b1;
    tick();
    rd_en_b = 1'b0;
  endtask

  task automatic drain_reads();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    check("reads_pending", 256'(exp_a.size() + exp_b.size()), 256'(0));
  endtask

  task automatic check_cleared_a(input string tag);
    check({tag, "_done"}, 256'(done_a), 256'(0));
    check({tag, "_busy"}, 256'(busy_a), 256'(0));
    check({tag, "_rd_vld"}, 256'(rd_vld_a), 256'(0));
    check({tag, "_err"}, 256'(err_a), 256'(0));
    check({tag, "_mcnt_first"}, 256'(mcnt_first_a), 256'(0));
    check({tag, "_rd_data"}, rd_data_a, 256'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test required finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [151:0] dsat;
    logic [159:0] esat;

    rst = 1'b1; arm_a = 1'b0; arm_b = 1'b0; acc_len = '0; din_sync = 1'b0; din_vld = 1'b0;
    din = '0; din_mcnt = '0; rd_en_a = 1'b0; rd_en_b = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check_cleared_a("reset");
    check("reset_b_busy", 256'(busy_b), 256'(0));
    check("reset_b_state", 256'({done_b, err_b, mcnt_first_b}), 256'(0));
    rst = 1'b0;
    tick();

    // Test 1: single window, word k field f = k + 16f; vld before sync is ignored.
    arm_dut_a(1);
    check("t1_busy_after_arm", 256'(busy_a), 256'(1));
    send(1'b0, mk_din(77, 0), 48'd1);
    send(1'b0, mk_din(78, 0), 48'd2);
    for (int k = 0; k < 12; k++) send(k == 0, mk_din(k, 16), 48'(1000 + k));
    wait_done(1'b0, lat);
    check("t1_done_latency", 256'(lat), 256'(3));
    check("t1_mcnt_first", 256'(mcnt_first_a), 256'(1000));
    check("t1_err", 256'(err_a), 256'(0));
    check("t1_busy_done", 256'(busy_a), 256'(0));
    for (int k = 0; k < 12; k++) read_a(k, mk_exp(k, 16));
    read_a(12, 256'(0));
    read_a(15, 256'(0));
    drain_reads();

    // Test 2: three windows of -5, sync repeated at each window start (no effect).
    arm_dut_a(3);
    for (int w = 0; w < 3; w++) send_window(1'b1, -5, 0, 2000 + 100 * w);
    wait_done(1'b0, lat);
    check("t2_done_latency", 256'(lat), 256'(3));
    check("t2_err", 256'(err_a), 256'(0));
    check("t2_mcnt_first", 256'(mcnt_first_a), 256'(2000));
    read_a(0, mk_exp(-15, 0));
    read_a(5, mk_exp(-15, 0));
    read_a(11, mk_exp(-15, 0));
    drain_reads();

    // Test 3: 20-bit accumulator saturates both ways over 8 windows.
    dsat = mk_din(262143, 0);
    dsat[18:0] = 19'h40000;
    for (int f = 0; f < 7; f++) esat[(7 - f) * 20 +: 20] = 20'h7FFFF;
    esat[19:0] = 20'h80000;
    acc_len = 16'd8;
    arm_b = 1'b1;
    tick();
    arm_b = 1'b0;
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < 12; k++) send((w == 0) && (k == 0), dsat, 48'(3000 + k));
    wait_done(1'b1, lat);
    check("t3_err_sat", 256'(err_b), 256'(3'b100));
    check("t3_busy", 256'(busy_b), 256'(0));
    read_b(0, esat);
    read_b(11, esat);
    drain_reads();

    // Test 4: resync at word 5 of window 1; two clean windows of 7+f follow.
    arm_dut_a(2);
    send_window(1'b1, 100, 0, 4000);
    for (int k = 0; k < 5; k++) send(1'b0, mk_din(100, 0), 48'(4100 + k));
    send(1'b1, mk_din(7, 1), 48'd5000);
    for (int k = 1; k < 12; k++) send(1'b0, mk_din(7, 1), 48'(5000 + k));
    send_window(1'b0, 7, 1, 5100);
    wait_done(1'b0, lat);
    check("t4_done_latency", 256'(lat), 256'(3));
    check("t4_err_resync", 256'(err_a), 256'(3'b010));
    check("t4_mcnt_first", 256'(mcnt_first_a), 256'(5000));
    read_a(0, mk_exp(14, 2));
    read_a(4, mk_exp(14, 2));
    read_a(5, mk_exp(14, 2));
    read_a(11, mk_exp(14, 2));
    drain_reads();

    // Test 5: reads while busy are dropped; a 13th word during drain is an overrun.
    arm_dut_a(1);
    rd_addr = 4'd0;
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
    tick();
    tick();
    check("t5_rd_vld_wait_sync", 256'(rd_vld_a), 256'(0));
    for (int k = 0; k < 12; k++) begin
      rd_en_a = (k == 4);
      send(k == 0, mk_din(3, 2), 48'(7000 + k));
      rd_en_a = 1'b0;
      if (k == 6) check("t5_rd_vld_accum", 256'(rd_vld_a), 256'(0));
    end
    send(1'b0, mk_din(99, 0), 48'd7012);
    wait_done(1'b0, lat);
    check("t5_err_overrun", 256'(err_a), 256'(3'b001));
    read_a(0, mk_exp(3, 2));
    read_a(11, mk_exp(3, 2));
    drain_reads();

    // Test 6: reset at word 7, then a full re-capture must show no residue.
    arm_dut_a(1);
    for (int k = 0; k < 7; k++) send(k == 0, mk_din(50, 0), 48'(6000 + k));
    rst = 1'b1;
    din_vld = 1'b1;
    din = mk_din(50, 0);
    tick();
    din_vld = 1'b0;
    check_cleared_a("t6_rst");
    rst = 1'b0;
    tick();
    arm_dut_a(2);
    send_window(1'b1, 1, 1, 8000);
    send_window(1'b0, 2, 1, 8100);
    wait_done(1'b0, lat);
    check("t6_done_latency", 256'(lat), 256'(3));
    check("t6_err", 256'(err_a), 256'(0));
    check("t6_mcnt_first", 256'(mcnt_first_a), 256'(8000));
    for (int k = 0; k < 12; k++) read_a(k, mk_exp(3, 2));
    drain_reads();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xeng_out_capture.md
Name: xeng_out_capture

Overview:
- Consumes the X-engine output stream (dout, vld_out, sync_out, mcnt_out) and labels each word by arrival position.
- Integrates ACC_LEN consecutive correlator windows per baseline word into a BRAM vector accumulator.
- Exposes the result through a read port for CPU/bench readout.
- Sits directly downstream of xeng_top, replacing ad-hoc output monitoring with synthesizable capture.

Parameters:
- N_ANTS, 32, dual-pol antenna count; OUT_WORDS = N_ANTS*(N_ANTS/2+1) words per window.
- IN_FIELD_W, 19, signed width of one corrected stokes field; din width = 8*IN_FIELD_W.
- OUT_FIELD_W, 32, signed width of one accumulated field.
- MCNT_WIDTH, 48, mcnt bus width.
- ACC_LEN_W, 16, width of the acc_len input.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- arm  in  1  one-cycle pulse: start a new capture.
- acc_len  in  ACC_LEN_W  windows to integrate; 0 treated as 1; sampled on arm.
- din_sync  in  1  xeng sync_out.
- din_vld  in  1  xeng vld_out.
- din  in  8*IN_FIELD_W  xeng dout; fields MSB-first xx_r,xx_i,xy_r,xy_i,yx_r,yx_i,yy_r,yy_i.
- din_mcnt  in  MCNT_WIDTH  xeng mcnt_out.
- rd_en  in  1  read request.
- rd_addr  in  clog2(OUT_WORDS)  word address.
- rd_data  out  8*OUT_FIELD_W  accumulated word, same field order.
- rd_vld  out  1  rd_data valid.
- busy  out  1  state is WAIT_SYNC or ACCUM.
- done  out  1  capture complete, held until arm/rst.
- mcnt_first  out  MCNT_WIDTH  din_mcnt of word 0 of window 0.
- err  out  3  sticky {sat, resync, overrun}.

Behaviour:
- Reset: state IDLE; done, busy, rd_vld, err, mcnt_first, rd_data all 0. RAM contents undefined.
- States and transitions:
  - IDLE: waits for arm.
  - WAIT_SYNC: waits for din_sync.
  - ACCUM: integrates windows.
  - DONE: holds the result.
- arm in any state -> WAIT_SYNC next cycle; clears done and err; latches acc_len; resets win_cnt and word_cnt.
- WAIT_SYNC: din_vld ignored. On din_sync -> ACCUM, word_cnt=0, win_cnt=0. A din_vld coincident with din_sync is word 0.
- ACCUM, per din_vld:
  - addr = word_cnt; word_cnt increments.
  - At OUT_WORDS-1, word_cnt wraps to 0 and win_cnt increments.
- Read-modify-write pipeline:
  - S0: issue RAM read, register din.
  - S1: RAM data valid; per field, sign-extend din to OUT_FIELD_W and add.
  - S2: write back.
  - During win_cnt==0, S2 writes the sign-extended din instead of the sum, so no RAM clear is needed.
- No address hazard: each address is written once per window, and consecutive windows revisit an address at least OUT_WORDS cycles later.
- Addition saturates at signed OUT_FIELD_W limits; saturation sets err[2].
- Last word of window acc_len-1 -> wait 2 cycles for pipeline drain -> DONE; done=1.
- din_sync in ACCUM:
  - word_cnt==0: no effect.
  - word_cnt!=0: set err[1], restart with word_cnt=0, win_cnt=0, overwrite mode.
- din_vld after the final word (stale words during drain or DONE): ignored, err[0] set.
- Readout:
  - rd_en honoured in IDLE/DONE; rd_data/rd_vld appear 2 cycles later.
  - rd_en in WAIT_SYNC/ACCUM: ignored, rd_vld stays 0.
  - rd_addr >= OUT_WORDS: rd_vld=1, rd_data=0.
- mcnt_first latched on word 0 of window 0, including after a resync restart.
- arm during ACCUM: up to 2 in-flight writes complete and are overwritten by the next window 0.
- rst mid-operation: immediate IDLE; in-flight writes suppressed.

Decomposition:
- Package xcap_pkg holds:
  - functions out_words(N_ANTS) and clog2;
  - field-index constants XX_R..YY_I;
  - state enum encoding;
  - err bit positions.
- Sub-module xcap_acc_ram: simple dual-port RAM, OUT_WORDS x 8*OUT_FIELD_W, registered read, 1-cycle read latency.
- The readout mux adds one further register stage, giving 2 cycles total.

Test Plan:
- N_ANTS=4 (OUT_WORDS=12), acc_len=1, arm, sync, 12 vld words with every field = word index -> done after last word + 3 cycles; rd addr k returns all fields = k; mcnt_first = mcnt of word 0.
- acc_len=3, all fields = -5 each window -> every field reads -15; err=0.
- Fields = 0x3FFFF, OUT_FIELD_W=20, acc_len=8 -> field saturates at 524287; err[2]=1.
- din_sync at word 5 of window 1 -> err[1]=1; result equals acc_len clean windows counted from the resync.
- 13th vld after final window -> err[0]=1, RAM unchanged; rd_en during ACCUM -> rd_vld stays 0.
- rst asserted at word 7 -> all outputs 0 next cycle; re-arm and full capture -> correct sums with no residue.
